// File: rtl/demux_pkg.sv
// Shared widths and channel state encoding for the 1-to-8 word distributor.
package demux_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned N_CH   = 8;
  localparam int unsigned SEL_W  = 3;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic {
    CH_EMPTY = 1'b0,
    CH_FULL  = 1'b1
  } chan_state_e;

endpackage

// File: rtl/demux_chan_reg.sv
// One-entry holding register: a write fills or refills the slot, and an ack with no write empties it.
module demux_chan_reg
  import demux_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              ack,
  output logic [DATA_W-1:0] data_q,
  output logic              valid_q
);

  chan_state_e       state_q;
  chan_state_e       state_d;
  logic [DATA_W-1:0] data_d;

  // State and data registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CH_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  // Write wins over ack, so a same-cycle ack and write leaves the slot full
  always_comb begin
    state_d = state_q;
    if (wr_en) begin
      state_d = CH_FULL;
    end else if (ack && (state_q == CH_FULL)) begin
      state_d = CH_EMPTY;
    end
  end

  // Data is only replaced on a write and is never cleared by an ack
  always_comb begin
    data_d = data_q;
    if (wr_en) begin
      data_d = wr_data;
    end
  end

  assign valid_q = (state_q == CH_FULL);

endmodule

// File: rtl/demux_behave_1x8_dist.sv
// Registered 1-to-8 distributor: steers accepted words into eight holding slots,
// selected either manually or by a round-robin pointer that never skips a stalled slot.
module demux_behave_1x8_dist
  import demux_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_selec1,
  input  logic              in_selec2,
  input  logic              in_selec3,
  input  logic              in_auto,
  output logic [DATA_W-1:0] out_y_1,
  output logic [DATA_W-1:0] out_y_2,
  output logic [DATA_W-1:0] out_y_3,
  output logic [DATA_W-1:0] out_y_4,
  output logic [DATA_W-1:0] out_y_5,
  output logic [DATA_W-1:0] out_y_6,
  output logic [DATA_W-1:0] out_y_7,
  output logic [DATA_W-1:0] out_y_8,
  output logic [N_CH-1:0]   out_valid,
  input  logic [N_CH-1:0]   in_ack,
  output logic [SEL_W-1:0]  out_ptr,
  output logic [CNT_W-1:0]  out_accept_cnt
);

  logic [SEL_W-1:0]  sel_c;
  logic [SEL_W-1:0]  tgt_c;
  logic              accept_c;
  logic [N_CH-1:0]   wr_en_c;
  logic [N_CH-1:0]   valid_q;
  logic [DATA_W-1:0] y_q [N_CH];
  logic [SEL_W-1:0]  ptr_q;
  logic [CNT_W-1:0]  cnt_q;

  assign sel_c    = {in_selec3, in_selec2, in_selec1};
  assign tgt_c    = in_auto ? ptr_q : sel_c;
  // Ready depends only on the target slot, so an ack in the same cycle frees it for refill
  assign in_ready = ~valid_q[tgt_c] | in_ack[tgt_c];
  assign accept_c = in_valid & in_ready;

  always_comb begin
    wr_en_c        = '0;
    wr_en_c[tgt_c] = accept_c;
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_chan
    demux_chan_reg u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en_c[k]),
      .wr_data (in_data),
      .ack     (in_ack[k]),
      .data_q  (y_q[k]),
      .valid_q (valid_q[k])
    );
  end

  // Pointer moves only on an auto-mode accept; counter counts every accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else if (accept_c) begin
      cnt_q <= cnt_q + CNT_W'(1);
      if (in_auto) begin
        ptr_q <= ptr_q + SEL_W'(1);
      end
    end
  end

  assign out_valid      = valid_q;
  assign out_ptr        = ptr_q;
  assign out_accept_cnt = cnt_q;
  assign out_y_1        = y_q[0];
  assign out_y_2        = y_q[1];
  assign out_y_3        = y_q[2];
  assign out_y_4        = y_q[3];
  assign out_y_5        = y_q[4];
  assign out_y_6        = y_q[5];
  assign out_y_7        = y_q[6];
  assign out_y_8        = y_q[7];

endmodule

// File: doc/demux_behave_1x8_dist.md
# demux_behave_1x8_dist

Registered 1-to-8 demultiplexer and distributor for 16-bit words; the write-side counterpart of the 8:1 selection path. Each accepted input word is steered into one of eight one-entry holding registers. The target comes from a 3-bit select or from an internal round-robin pointer. Each output channel offers its word with a valid/ack handshake and backpressures the input when the selected slot is still occupied.

## Interface
Parameters:
- DATA_W, 16, word width of input and every output channel.
- N_CH, 8, number of output channels; fixed at 8 because the select is 3 bits.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_data  input  16  word to distribute.
- in_valid  input  1  in_data is offered this cycle.
- in_ready  output  1  a word offered this cycle will be accepted.
- in_selec1, in_selec2, in_selec3  input  1 each  manual channel select; index = {in_selec3, in_selec2, in_selec1}; index 0 selects out_y_1 and index 7 selects out_y_8.
- in_auto  input  1  1 = round-robin pointer selects the channel; 0 = in_selec bits select it.
- out_y_1 … out_y_8  output  16 each  held word of channels 1..8.
- out_valid  output  8  bit k set means out_y_(k+1) holds an unconsumed word.
- in_ack  input  8  consumer k takes its word; meaningful only while out_valid[k]=1.
- out_ptr  output  3  current round-robin pointer.
- out_accept_cnt  output  8  total accepted words, wraps at 255 to 0.

## Operation
- Target index t = in_auto ? out_ptr : {in_selec3,in_selec2,in_selec1}. t is combinational from current inputs and state.
- in_ready = ~out_valid[t] | in_ack[t]. A full slot can accept a new word in the same cycle it is acked (pass-through refill).
- Accept = in_valid & in_ready. On accept, the rising edge writes in_data into channel t, keeps out_valid[t] at 1, and increments out_accept_cnt.
- Channel k with in_ack[k]=1 and no write to k in that cycle: out_valid[k] clears at the next edge. out_y_(k+1) keeps its last value; data is not cleared on ack.
- in_ack[k] while out_valid[k]=0 is ignored.
- Acks on any channels and one write to channel t can all occur in the same cycle, independently.
- Pointer: advances by 1 (7 wraps to 0) only on an accept with in_auto=1. It holds while in_auto=0. It also holds on stalls: in auto mode a blocked channel stalls the input, and the pointer does not skip it.
- Changing in_auto or the select bits while in_valid=1 and in_ready=0 is legal. The new target is evaluated in that same cycle.
- Per-channel state is EMPTY or FULL. EMPTY→FULL on a write. FULL→EMPTY on an ack with no write. FULL→FULL on a write, with or without an ack.

## Timing
- Reset values (asynchronous, take effect immediately on rst_n low): out_valid=8'h00, all out_y_ = 16'h0000, out_ptr=0, out_accept_cnt=0.
- Since all slots are empty in reset, in_ready follows the combinational rule and reads 1.
- Latency: word accepted at edge n appears on out_y_ and out_valid from edge n onward; one register stage.
- Throughput: one word per cycle, including to the same channel if its consumer acks every cycle.
- in_ready has a combinational path from in_ack, in_selec*, and in_auto. It has no combinational path from in_valid.
- Reset asserted mid-transfer discards all held words and pointer state. The first accept after rst_n deasserts goes to channel 0 in auto mode.
- out_accept_cnt wraps 255→0 with no flag.

## Structure
- Shared package demux_pkg holds DATA_W=16, N_CH=8, SEL_W=3, and the channel state encoding (EMPTY=0, FULL=1).
- Sub-module demux_chan_reg is instantiated 8 times. It is a one-entry holding register with ports clk, rst_n, wr_en, wr_data, ack, data_q, and valid_q, and it implements the EMPTY/FULL rules above.
- The top level holds target select, the in_ready mux, the round-robin pointer, and the accept counter.

## Test plan
- Reset and manual select: after reset, drive select index 5, in_data=16'hA5A5, one-cycle valid. Expect out_y_6=16'hA5A5, out_valid=8'b0010_0000, out_accept_cnt=1, all other out_y_=0.
- Backpressure: with channel 6 full and in_ack=0, offer a second word to index 5. Expect in_ready=0 and out_y_6 unchanged. Raise in_ack[5] in that same cycle: expect in_ready=1, out_y_6 takes the new word, out_valid[5] stays 1.
- Round robin: in_auto=1, all acks tied 1, nine words 16'h0001..16'h0009. Expect channels 1..8 to get 1..8, then channel 1 to get 9, and out_ptr=1 afterwards.
- Stall without skip: in_auto=1, channel 3 full with in_ack[2]=0, pointer at 2. Expect in_ready=0 and out_ptr to stay 2 for 4 cycles. Ack channel 3: the word lands in channel 3 and out_ptr becomes 3.
- Ack-only drain: channel 8 full, in_ack[7]=1 with no write. Expect out_valid[7]=0 next cycle and out_y_8 retaining its value. An ack on an empty channel changes nothing.
- Asynchronous reset: assert rst_n low mid-cycle with channels 1, 4, and 7 full and the counter at 200. Expect out_valid=0, out_ptr=0, and out_accept_cnt=0 before the next clock edge. Separately, 256 accepts wrap the counter to 0.
